// File: rtl/reg_file_master.sv
// Serial register-file master: 1-cycle command strobe, 8 address bits, 8 data bits (MSB first), DONE pulse, idle gap.
// Define REG_FILE_MASTER_RDBACK_EN to follow every write with a readback of the same address and flag mismatches on WR_ERR.
module reg_file_master #(
  parameter int unsigned IDLE_GAP = 1
) (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic       REQ,
  input  logic       WE,
  input  logic [7:0] ADDR,
  input  logic [7:0] WDATA,
  output logic       READY,
  output logic       DONE,
  output logic [7:0] RDATA,
  output logic       RVALID,
  output logic       WR_ERR,
  output logic       RD_EN,
  output logic       WR_EN,
  output logic       DIN,
  input  logic       DOUT
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_GAP
  } state_t;

  localparam logic [3:0] GAP_LAST = 4'(IDLE_GAP);

  state_t      state;
  logic [3:0]  cnt;
  logic        is_wr;
  logic        wr_phase;
  logic [7:0]  addr_q;
  logic [7:0]  wdata_q;
  logic [6:0]  shift_q;
  logic [7:0]  rd_byte;

`ifdef REG_FILE_MASTER_RDBACK_EN
  logic        rb;
  assign wr_phase = is_wr & ~rb;
`else
  assign wr_phase = is_wr;
`endif

  assign rd_byte = {shift_q, DOUT};

  // Transaction payload is captured on accept and never reset; control below qualifies its use.
  always_ff @(posedge CLK) begin
    if (state == ST_IDLE && REQ) begin
      addr_q  <= ADDR;
      wdata_q <= WDATA;
    end
    if (state == ST_DATA && !wr_phase) shift_q <= {shift_q[5:0], DOUT};
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state  <= ST_IDLE;
      cnt    <= 4'd0;
      is_wr  <= 1'b0;
`ifdef REG_FILE_MASTER_RDBACK_EN
      rb     <= 1'b0;
`endif
      READY  <= 1'b1;
      DONE   <= 1'b0;
      RVALID <= 1'b0;
      WR_ERR <= 1'b0;
      RD_EN  <= 1'b0;
      WR_EN  <= 1'b0;
      DIN    <= 1'b0;
      RDATA  <= 8'h00;
    end else begin
      // Pulses and the serial line default low every cycle.
      DONE   <= 1'b0;
      RVALID <= 1'b0;
      WR_ERR <= 1'b0;
      RD_EN  <= 1'b0;
      WR_EN  <= 1'b0;
      DIN    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (REQ) begin
            state <= ST_CMD;
            READY <= 1'b0;
            is_wr <= WE;
`ifdef REG_FILE_MASTER_RDBACK_EN
            rb    <= 1'b0;
`endif
            WR_EN <= WE;
            RD_EN <= ~WE;
          end
        end
        ST_CMD: begin
          state <= ST_ADDR;
          cnt   <= 4'd0;
          DIN   <= addr_q[7];
        end
        ST_ADDR: begin
          if (cnt == 4'd7) begin
            state <= ST_DATA;
            cnt   <= 4'd0;
            DIN   <= wr_phase ? wdata_q[7] : 1'b0;
          end else begin
            cnt <= cnt + 4'd1;
            DIN <= addr_q[3'd6 - cnt[2:0]];
          end
        end
        ST_DATA: begin
          if (cnt != 4'd7) begin
            cnt <= cnt + 4'd1;
            DIN <= wr_phase ? wdata_q[3'd6 - cnt[2:0]] : 1'b0;
          end else begin
`ifdef REG_FILE_MASTER_RDBACK_EN
            if (wr_phase) begin
              // Readback command goes out in the cycle right after the write data.
              rb    <= 1'b1;
              RD_EN <= 1'b1;
              state <= ST_CMD;
            end else begin
              DONE   <= 1'b1;
              RVALID <= 1'b1;
              RDATA  <= rd_byte;
              WR_ERR <= rb && (rd_byte != wdata_q);
              state  <= ST_GAP;
              cnt    <= 4'd0;
            end
`else
            DONE <= 1'b1;
            if (!is_wr) begin
              RVALID <= 1'b1;
              RDATA  <= rd_byte;
            end
            state <= ST_GAP;
            cnt   <= 4'd0;
`endif
          end
        end
        ST_GAP: begin
          // First GAP cycle is the DONE cycle; IDLE_GAP more follow before READY.
          if (cnt == GAP_LAST) begin
            state <= ST_IDLE;
            READY <= 1'b1;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          READY <= 1'b1;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_file_master.sv
// Directed bench for reg_file_master with a serial slave model (0x34/0x78 RW, 0x55 RO = 0x33, rest reads 0).
module tb_reg_file_master;

  logic       CLK = 1'b0;
  logic       RSTN;
  logic       REQ;
  logic       WE;
  logic [7:0] ADDR;
  logic [7:0] WDATA;
  logic       READY, DONE, RVALID, WR_ERR, RD_EN, WR_EN, DIN, DOUT;
  logic [7:0] RDATA;

  int total = 0;
  int bad   = 0;

  reg_file_master #(.IDLE_GAP(0)) dut (
    .CLK(CLK), .RSTN(RSTN), .REQ(REQ), .WE(WE), .ADDR(ADDR), .WDATA(WDATA),
    .READY(READY), .DONE(DONE), .RDATA(RDATA), .RVALID(RVALID), .WR_ERR(WR_ERR),
    .RD_EN(RD_EN), .WR_EN(WR_EN), .DIN(DIN), .DOUT(DOUT)
  );

  always #5 CLK = ~CLK;

  // Slave model
  logic [7:0] mem34 = 8'h00;
  logic [7:0] mem78 = 8'h00;
  int         slv_cnt = 0;
  logic       slv_wr = 1'b0;
  logic [7:0] slv_addr = 8'h00;
  logic [7:0] slv_data = 8'h00;
  logic [7:0] slv_byte;
  logic [7:0] slv_wbyte;

  always @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      slv_cnt <= 0;
    end else if (WR_EN || RD_EN) begin
      slv_cnt <= 1;
      slv_wr  <= WR_EN;
    end else if (slv_cnt != 0) begin
      if (slv_cnt <= 8) slv_addr <= {slv_addr[6:0], DIN};
      else if (slv_wr)  slv_data <= {slv_data[6:0], DIN};
      if (slv_cnt == 16) begin
        slv_cnt <= 0;
        if (slv_wr && slv_addr == 8'h34) mem34 <= slv_wbyte;
        if (slv_wr && slv_addr == 8'h78) mem78 <= slv_wbyte;
      end else begin
        slv_cnt <= slv_cnt + 1;
      end
    end
  end

  always_comb begin
    slv_wbyte = {slv_data[6:0], DIN};
    case (slv_addr)
      8'h34:   slv_byte = mem34;
      8'h78:   slv_byte = mem78;
      8'h55:   slv_byte = 8'h33;
      default: slv_byte = 8'h00;
    endcase
    DOUT = 1'b0;
    if (!slv_wr && slv_cnt >= 9 && slv_cnt <= 16) DOUT = slv_byte[16 - slv_cnt];
  end

  // Results of the last transaction
  logic        t0_wr, t0_rd, both, rvalid_o, werr_o, done_after, ready_after;
  logic [15:0] din_bits;
  logic [7:0]  rdata_o, rdata_hold;
  int          done_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with READY high; returns at the negedge after the DONE cycle.
  task automatic txn(input logic we, input logic [7:0] a, input logic [7:0] wd);
    REQ = 1'b1; WE = we; ADDR = a; WDATA = wd;
    @(negedge CLK);
    REQ = 1'b0; WE = ~we; ADDR = ~a; WDATA = ~wd;
    t0_wr = WR_EN; t0_rd = RD_EN; both = WR_EN & RD_EN;
    din_bits = 16'h0; done_t = -1;
    rdata_o = 8'hxx; rvalid_o = 1'bx; werr_o = 1'bx;
    for (int k = 1; k <= 40 && done_t < 0; k++) begin
      @(negedge CLK);
      if (k <= 16) din_bits = {din_bits[14:0], DIN};
      if (WR_EN && RD_EN) both = 1'b1;
      if (DONE) begin
        done_t = k; rdata_o = RDATA; rvalid_o = RVALID; werr_o = WR_ERR;
      end
    end
    @(negedge CLK);
    done_after = DONE; ready_after = READY; rdata_hold = RDATA;
  endtask

  int t0s[4];
  int n_t0, n_done, n_bad_rd, wait_c;

  initial begin
    RSTN = 1'b0; REQ = 1'b0; WE = 1'b0; ADDR = 8'h00; WDATA = 8'h00;
    repeat (3) @(negedge CLK);
    chk("reset_outs", {READY, DONE, RVALID, WR_ERR, RD_EN, WR_EN, DIN, RDATA}, {7'b1000000, 8'h00});
    RSTN = 1'b1;

    txn(1'b0, 8'h55, 8'h00);
    chk("rd55_t0_rd", t0_rd, 1'b1);
    chk("rd55_t0_wr", t0_wr, 1'b0);
    chk("rd55_din", din_bits, 16'h5500);
    chk("rd55_done_t", 32'(done_t), 32'd17);
    chk("rd55_rdata", rdata_o, 8'h33);
    chk("rd55_rvalid", rvalid_o, 1'b1);
    chk("rd55_wr_err", werr_o, 1'b0);
    chk("rd55_done_pulse", done_after, 1'b0);
    chk("rd55_ready_t18", ready_after, 1'b1);
    chk("rd55_rdata_hold", rdata_hold, 8'h33);

    txn(1'b0, 8'h00, 8'h00);
    chk("rd00_rdata", rdata_o, 8'h00);
    chk("rd00_done_t", 32'(done_t), 32'd17);

    txn(1'b1, 8'h34, 8'hA5);
    chk("wr34_t0_wr", t0_wr, 1'b1);
    chk("wr34_t0_rd", t0_rd, 1'b0);
    chk("wr34_both", both, 1'b0);
    chk("wr34_din", din_bits, 16'h34A5);
`ifdef REG_FILE_MASTER_RDBACK_EN
    chk("wr34_done_t", 32'(done_t), 32'd34);
    chk("wr34_rvalid", rvalid_o, 1'b1);
    chk("wr34_rdata", rdata_o, 8'hA5);
`else
    chk("wr34_done_t", 32'(done_t), 32'd17);
    chk("wr34_rvalid", rvalid_o, 1'b0);
    chk("wr34_rdata_held", rdata_o, 8'h00);
`endif
    chk("wr34_wr_err", werr_o, 1'b0);

    txn(1'b0, 8'h34, 8'h00);
    chk("rd34_a_rdata", rdata_o, 8'hA5);
    chk("rd34_a_rvalid", rvalid_o, 1'b1);
    chk("rd34_a_done_t", 32'(done_t), 32'd17);
    txn(1'b0, 8'h34, 8'h00);
    chk("rd34_b_rdata", rdata_o, 8'hA5);

    // Abort a write at T10.
    REQ = 1'b1; WE = 1'b1; ADDR = 8'h34; WDATA = 8'h5A;
    @(negedge CLK);
    REQ = 1'b0;
    repeat (10) @(negedge CLK);
    RSTN = 1'b0;
    #1;
    chk("abort_async", {READY, DONE, RVALID, WR_ERR, RD_EN, WR_EN, DIN, RDATA}, {7'b1000000, 8'h00});
    @(negedge CLK);
    chk("abort_next", {READY, DONE, RVALID, WR_ERR, RD_EN, WR_EN, DIN, RDATA}, {7'b1000000, 8'h00});
    RSTN = 1'b1;
    n_done = 0;
    repeat (20) begin
      @(negedge CLK);
      if (DONE || RD_EN || WR_EN) n_done++;
    end
    chk("abort_quiet", 32'(n_done), 32'd0);
    txn(1'b0, 8'h34, 8'h00);
    chk("abort_rd34_done_t", 32'(done_t), 32'd17);
    chk("abort_rd34_rdata", rdata_o, 8'hA5);

    // REQ held high: back-to-back reads of 0x55.
    REQ = 1'b1; WE = 1'b0; ADDR = 8'h55;
    n_t0 = 0; n_done = 0; n_bad_rd = 0;
    for (int c = 0; c < 70; c++) begin
      @(negedge CLK);
      if (RD_EN) begin
        if (n_t0 < 4) t0s[n_t0] = c;
        n_t0++;
      end
      if (WR_EN) n_bad_rd++;
      if (DONE) begin
        n_done++;
        if (RDATA !== 8'h33 || RVALID !== 1'b1) n_bad_rd++;
      end
    end
    REQ = 1'b0;
    chk("b2b_n_t0", 32'(n_t0), 32'd4);
    chk("b2b_first_t0", 32'(t0s[0]), 32'd0);
    chk("b2b_gap1", 32'(t0s[1] - t0s[0]), 32'd19);
    chk("b2b_gap2", 32'(t0s[2] - t0s[1]), 32'd19);
    chk("b2b_gap3", 32'(t0s[3] - t0s[2]), 32'd19);
    chk("b2b_n_done", 32'(n_done), 32'd3);
    chk("b2b_bad", 32'(n_bad_rd), 32'd0);
    wait_c = 0;
    while (!READY && wait_c < 40) begin
      @(negedge CLK);
      wait_c++;
    end
    chk("b2b_ready_return", READY, 1'b1);

`ifdef REG_FILE_MASTER_RDBACK_EN
    txn(1'b1, 8'h78, 8'h5A);
    chk("rb78_done_t", 32'(done_t), 32'd34);
    chk("rb78_wr_err", werr_o, 1'b0);
    chk("rb78_rdata", rdata_o, 8'h5A);
    txn(1'b1, 8'h55, 8'hFF);
    chk("rb55_done_t", 32'(done_t), 32'd34);
    chk("rb55_wr_err", werr_o, 1'b1);
    chk("rb55_rdata", rdata_o, 8'h33);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
